kinase_valve_sequencer: RTL and testbench

- Drives the control-side pads of the kinase activity chip: 13 `ctrl_a` valves, 4 `ctrl_s` valves, the 3-valve peristaltic pump A and the 2-valve pump B.
- Executes a host-loaded step program. Each step sets static valve states, pump enables and a dwell time.
- Pump phase patterns are generated internally.
- Sits off-chip in the controller FPGA. Its outputs feed the pneumatic solenoid drivers that connect to `pad_ctrl_*` / `pad_pump_*`.

---
 rtl/kinase_valve_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_kinase_valve_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kinase_valve_sequencer.sv
// Step-program sequencer for the kinase chip control pads: static valves, two
// peristaltic pumps and a per-step dwell timer. Every output is a flop.
module kinase_valve_sequencer #(
  parameter int DEPTH   = 16,
  parameter int DWELL_W = 16,
  parameter int DIV_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [22+DWELL_W:0]      wr_data,
  input  logic                     start,
  input  logic                     abort,
  input  logic [DIV_W-1:0]         pump_period,
  output logic [12:0]              ctrl_a,
  output logic [3:0]               ctrl_s,
  output logic [2:0]               pump_a,
  output logic [1:0]               pump_b,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] step_idx,
  output logic                     wr_err
);
  // state | meaning
  // IDLE  | valves released, program memory writable, waiting for start
  // RUN   | current step driven, dwell down-counter running
  // DONE  | one-cycle completion pulse, valves released

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic               last;
    logic               pb_en;
    logic               pa_dir;
    logic               pa_en;
    logic [3:0]         ctrl_s;
    logic [12:0]        ctrl_a;
    logic [DWELL_W-1:0] dwell;
  } step_t;

  step_t              mem [DEPTH];
  step_t              rd_step;
  state_t             state_q, state_d;
  logic               load, clear;
  logic [AW-1:0]      load_idx, idx_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [12:0]        a_d;
  logic [3:0]         s_d;
  logic               pa_en_q, pa_en_d, pa_dir_q, pa_dir_d, pb_en_q, pb_en_d;
  logic               last_q, last_d, busy_d, done_d, wr_err_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               tick;
  logic [2:0]         pa_ph_q, pa_ph_d, pump_a_d;
  logic               pb_ph_q, pb_ph_d;
  logic [1:0]         pump_b_d;
  logic               unused_pad;

  assign unused_pad = ^wr_data[DWELL_W+1:DWELL_W];
  assign rd_step    = mem[load_idx];

  always_ff @(posedge clk) begin
    if (wr_en && state_q == S_IDLE)
      mem[wr_addr] <= {wr_data[22+DWELL_W:DWELL_W+2], wr_data[DWELL_W-1:0]};
  end

  function automatic logic [2:0] pa_pattern(input logic [2:0] ph);
    case (ph)
      3'd0:    pa_pattern = 3'b100;
      3'd1:    pa_pattern = 3'b110;
      3'd2:    pa_pattern = 3'b010;
      3'd3:    pa_pattern = 3'b011;
      3'd4:    pa_pattern = 3'b001;
      3'd5:    pa_pattern = 3'b101;
      default: pa_pattern = 3'b000;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    clear    = 1'b0;
    load_idx = '0;
    dwell_d  = dwell_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (dwell_q == '0) begin
          if (last_q || step_idx == IDX_LAST) begin
            state_d = S_DONE;
            clear   = 1'b1;
          end else begin
            load     = 1'b1;
            load_idx = step_idx + 1'b1;
          end
        end else begin
          dwell_d = dwell_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        clear   = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        clear   = 1'b1;
      end
    endcase
    // abort outranks both start and dwell expiry
    if (abort) begin
      state_d = S_IDLE;
      load    = 1'b0;
      clear   = 1'b1;
    end

    idx_d    = step_idx;
    a_d      = ctrl_a;
    s_d      = ctrl_s;
    pa_en_d  = pa_en_q;
    pa_dir_d = pa_dir_q;
    pb_en_d  = pb_en_q;
    last_d   = last_q;
    busy_d   = busy;
    if (load) begin
      idx_d    = load_idx;
      dwell_d  = (rd_step.dwell == '0) ? '0 : rd_step.dwell - 1'b1;
      a_d      = rd_step.ctrl_a;
      s_d      = rd_step.ctrl_s;
      pa_en_d  = rd_step.pa_en;
      pa_dir_d = rd_step.pa_dir;
      pb_en_d  = rd_step.pb_en;
      last_d   = rd_step.last;
      busy_d   = 1'b1;
    end
    if (clear) begin
      idx_d    = '0;
      dwell_d  = '0;
      a_d      = '0;
      s_d      = '0;
      pa_en_d  = 1'b0;
      pa_dir_d = 1'b0;
      pb_en_d  = 1'b0;
      last_d   = 1'b0;
      busy_d   = 1'b0;
    end
    done_d   = (state_q == S_RUN) && (state_d == S_DONE);
    wr_err_d = wr_en && (state_q != S_IDLE);
  end

  // Phase ticks use the step that was active this cycle, so a direction change
  // at a step boundary only affects ticks after the boundary.
  always_comb begin
    tick = (pa_en_q || pb_en_q) && (div_q >= pump_period);
    if (!(pa_en_d || pb_en_d) || !(pa_en_q || pb_en_q) || tick)
      div_d = '0;
    else
      div_d = div_q + 1'b1;

    pa_ph_d = pa_ph_q;
    if (!pa_en_d)
      pa_ph_d = 3'd0;
    else if (tick && pa_en_q) begin
      if (pa_dir_q)
        pa_ph_d = (pa_ph_q == 3'd0) ? 3'd5 : pa_ph_q - 3'd1;
      else
        pa_ph_d = (pa_ph_q == 3'd5) ? 3'd0 : pa_ph_q + 3'd1;
    end

    pb_ph_d = pb_ph_q;
    if (!pb_en_d)
      pb_ph_d = 1'b0;
    else if (tick && pb_en_q)
      pb_ph_d = ~pb_ph_q;

    pump_a_d = pa_en_d ? pa_pattern(pa_ph_d) : 3'b000;
    pump_b_d = pb_en_d ? (pb_ph_d ? 2'b01 : 2'b10) : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      step_idx <= '0;
      dwell_q  <= '0;
      ctrl_a   <= '0;
      ctrl_s   <= '0;
      pa_en_q  <= 1'b0;
      pa_dir_q <= 1'b0;
      pb_en_q  <= 1'b0;
      last_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_err   <= 1'b0;
      div_q    <= '0;
      pa_ph_q  <= 3'd0;
      pb_ph_q  <= 1'b0;
      pump_a   <= 3'b000;
      pump_b   <= 2'b00;
    end else begin
      state_q  <= state_d;
      step_idx <= idx_d;
      dwell_q  <= dwell_d;
      ctrl_a   <= a_d;
      ctrl_s   <= s_d;
      pa_en_q  <= pa_en_d;
      pa_dir_q <= pa_dir_d;
      pb_en_q  <= pb_en_d;
      last_q   <= last_d;
      busy     <= busy_d;
      done     <= done_d;
      wr_err   <= wr_err_d;
      div_q    <= div_d;
      pa_ph_q  <= pa_ph_d;
      pb_ph_q  <= pb_ph_d;
      pump_a   <= pump_a_d;
      pump_b   <= pump_b_d;
    end
  end

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Scoreboard bench for kinase_valve_sequencer: stimulus queues hand-computed
// per-cycle output snapshots, a monitor pops and compares one every mid-cycle.
module tb_kinase_valve_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [38:0] wr_data;
  logic        start;
  logic        abort;
  logic [7:0]  pump_period;
  logic [12:0] ctrl_a;
  logic [3:0]  ctrl_s;
  logic [2:0]  pump_a;
  logic [1:0]  pump_b;
  logic        busy;
  logic        done;
  logic [3:0]  step_idx;
  logic        wr_err;

  typedef struct packed {
    logic [12:0] a;
    logic [3:0]  s;
    logic [2:0]  pa;
    logic [1:0]  pb;
    logic        busy;
    logic        done;
    logic [3:0]  idx;
    logic        err;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  exp_t  mon_exp, mon_act;
  string mon_name;
  int    pass_cnt = 0;
  int    tot_cnt  = 0;

  kinase_valve_sequencer dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .abort(abort),
    .pump_period(pump_period), .ctrl_a(ctrl_a), .ctrl_s(ctrl_s),
    .pump_a(pump_a), .pump_b(pump_b), .busy(busy), .done(done),
    .step_idx(step_idx), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_exp  = sb.pop_front();
        mon_name = sb_name.pop_front();
        mon_act  = '{a: ctrl_a, s: ctrl_s, pa: pump_a, pb: pump_b, busy: busy,
                     done: done, idx: step_idx, err: wr_err};
        tot_cnt++;
        if (mon_act === mon_exp) pass_cnt++;
        else
          $display("FAIL %s: got a=%h s=%h pa=%b pb=%b busy=%b done=%b idx=%0d err=%b, want a=%h s=%h pa=%b pb=%b busy=%b done=%b idx=%0d err=%b",
                   mon_name, mon_act.a, mon_act.s, mon_act.pa, mon_act.pb, mon_act.busy,
                   mon_act.done, mon_act.idx, mon_act.err, mon_exp.a, mon_exp.s,
                   mon_exp.pa, mon_exp.pb, mon_exp.busy, mon_exp.done, mon_exp.idx,
                   mon_exp.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [38:0] mk(input int last, input int pb, input int dir,
                                     input int pa, input int s, input int a,
                                     input int dw);
    return {1'(last), 1'(pb), 1'(dir), 1'(pa), 4'(s), 13'(a), 2'b00, 16'(dw)};
  endfunction

  task automatic push(input string n, input int a, input int s, input int pa,
                      input int pb, input int b, input int d, input int idx,
                      input int e, input int rep);
    exp_t x;
    x = '{a: 13'(a), s: 4'(s), pa: 3'(pa), pb: 2'(pb), busy: 1'(b),
          done: 1'(d), idx: 4'(idx), err: 1'(e)};
    for (int k = 0; k < rep; k++) begin
      sb.push_back(x);
      sb_name.push_back(n);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [38:0] d);
    wr_en   = 1'b1;
    wr_addr = 4'(addr);
    wr_data = d;
    step_clk();
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 500 && sb.size() > 0; k++) step_clk();
    if (sb.size() > 0) begin
      tot_cnt++;
      $display("FAIL drain: %0d snapshots left unchecked, want 0", sb.size());
      sb.delete();
      sb_name.delete();
    end
  endtask

  task automatic push_full_run(input string tag);
    push({tag, "_idle"}, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++)
      push({tag, "_step"}, 'h100 + i, i, 0, 0, 1, 0, i, 0, 1);
    push({tag, "_done"}, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    push({tag, "_after"}, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; abort = 1'b0; pump_period = 8'd1;
    push("reset", 0, 0, 0, 0, 0, 0, 0, 0, 2);
    step_clk();
    step_clk();
    rst_n = 1'b1;
    wait_drain();

    // three-step program with a zero dwell in the middle
    wr(0, mk(0, 0, 0, 0, 0, 'h1FFF, 4));
    wr(1, mk(0, 0, 0, 0, 'hA, 0, 0));
    wr(2, mk(1, 0, 0, 0, 0, 'h0001, 2));
    push("basic_idle", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    push("basic_s0", 'h1FFF, 0, 0, 0, 1, 0, 0, 0, 4);
    push("basic_s1", 0, 'hA, 0, 0, 1, 0, 1, 0, 1);
    push("basic_s2", 'h0001, 0, 0, 0, 1, 0, 2, 0, 2);
    push("basic_done", 0, 0, 0, 0, 0, 1, 0, 0, 1);
    push("basic_after", 0, 0, 0, 0, 0, 0, 0, 0, 2);
    start = 1'b1;
    step_clk();
    start = 1'b0;
    wait_drain();

    // pump A forward, then reverse with pump B, then pumps off
    wr(0, mk(0, 0, 0, 1, 0, 0, 12));
    wr(1, mk(0, 1, 1, 1, 0, 0, 6));
    wr(2, mk(1, 0, 0, 0, 0, 0, 2));
    push("pump_idle", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    push("pa_fwd0", 0, 0, 'b100, 0, 1, 0, 0, 0, 2);
    push("pa_fwd1", 0, 0, 'b110, 0, 1, 0, 0, 0, 2);
    push("pa_fwd2", 0, 0, 'b010, 0, 1, 0, 0, 0, 2);
    push("pa_fwd3", 0, 0, 'b011, 0, 1, 0, 0, 0, 2);
    push("pa_fwd4", 0, 0, 'b001, 0, 1, 0, 0, 0, 2);
    push("pa_fwd5", 0, 0, 'b101, 0, 1, 0, 0, 0, 2);
    push("pa_wrap", 0, 0, 'b100, 'b10, 1, 0, 1, 0, 2);
    push("pa_rev5", 0, 0, 'b101, 'b01, 1, 0, 1, 0, 2);
    push("pa_rev4", 0, 0, 'b001, 'b10, 1, 0, 1, 0, 2);
    push("pa_off", 0, 0, 0, 0, 1, 0, 2, 0, 2);
    push("pump_done", 0, 0, 0, 0, 0, 1, 0, 0, 1);
    push("pump_after", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    start = 1'b1;
    step_clk();
    start = 1'b0;
    wait_drain();

    // abort in the second cycle of step 1
    wr(0, mk(0, 0, 0, 0, 1, 'h0003, 3));
    wr(1, mk(0, 1, 0, 1, 2, 'h0005, 5));
    wr(2, mk(0, 0, 0, 0, 4, 'h0007, 2));
    wr(3, mk(1, 0, 0, 0, 8, 'h0009, 2));
    push("ab_idle", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    push("ab_s0", 3, 1, 0, 0, 1, 0, 0, 0, 3);
    push("ab_s1", 5, 2, 'b100, 'b10, 1, 0, 1, 0, 2);
    push("ab_released", 0, 0, 0, 0, 0, 0, 0, 0, 3);
    start = 1'b1;
    step_clk();
    start = 1'b0;
    repeat (4) step_clk();
    abort = 1'b1;
    step_clk();
    abort = 1'b0;
    wait_drain();

    // restart from step 0, with a rejected write to slot 2 during RUN
    push("rs_idle", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    push("rs_s0", 3, 1, 0, 0, 1, 0, 0, 0, 1);
    push("rs_wr_err", 3, 1, 0, 0, 1, 0, 0, 1, 1);
    push("rs_s0", 3, 1, 0, 0, 1, 0, 0, 0, 1);
    push("rs_s1a", 5, 2, 'b100, 'b10, 1, 0, 1, 0, 2);
    push("rs_s1b", 5, 2, 'b110, 'b01, 1, 0, 1, 0, 2);
    push("rs_s1c", 5, 2, 'b010, 'b10, 1, 0, 1, 0, 1);
    push("rs_s2_kept", 7, 4, 0, 0, 1, 0, 2, 0, 2);
    push("rs_s3", 9, 8, 0, 0, 1, 0, 3, 0, 2);
    push("rs_done", 0, 0, 0, 0, 0, 1, 0, 0, 1);
    push("rs_after", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    start = 1'b1;
    step_clk();
    start = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = mk(1, 0, 0, 0, 'hF, 'h1ABC, 1);
    step_clk();
    wr_en = 1'b0;
    wait_drain();

    // every slot with last=0: ends after the final slot
    for (int i = 0; i < 16; i++) wr(i, mk(0, 0, 0, 0, i, 'h100 + i, 1));
    push_full_run("full");
    start = 1'b1;
    step_clk();
    start = 1'b0;
    wait_drain();

    // start and abort together in IDLE
    push("sa_idle", 0, 0, 0, 0, 0, 0, 0, 0, 4);
    start = 1'b1;
    abort = 1'b1;
    step_clk();
    start = 1'b0;
    abort = 1'b0;
    wait_drain();

    // async reset between edges during RUN
    push("rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    push("rst_s0", 'h100, 0, 0, 0, 1, 0, 0, 0, 1);
    push("rst_s1", 'h101, 1, 0, 0, 1, 0, 1, 0, 1);
    push("rst_s2", 'h102, 2, 0, 0, 1, 0, 2, 0, 1);
    push("rst_zero", 0, 0, 0, 0, 0, 0, 0, 0, 2);
    start = 1'b1;
    step_clk();
    start = 1'b0;
    repeat (3) step_clk();
    rst_n = 1'b0;
    step_clk();
    rst_n = 1'b1;
    wait_drain();

    // program memory survives reset
    push_full_run("post_rst");
    start = 1'b1;
    step_clk();
    start = 1'b0;
    wait_drain();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
